// File: rtl/lau_pkg.sv
// Shared types and sizing helpers for the sequential arithmetic units.
package lau_pkg;

  typedef enum logic {SMALL, FAST} speed_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sqr_state_e;

  function automatic int sqr_iter(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int sqr_cnt_w(input int width, input int digit);
    return $clog2(sqr_iter(width, digit) + 1);
  endfunction

endpackage

// File: rtl/sqr_seq_hs_step.sv
// Generic adder (speed selects carry structure) and one shift-add step of the squarer:
// sum = Ahi + M*D, combinational, width+digit+1 bits.
module Add
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] s
);

  generate
    if (speed == FAST) begin : g_fast
      assign s = a + b;
    end else begin : g_small
      logic c;
      always_comb begin
        s = '0;
        c = 1'b0;
        for (int i = 0; i < width; i++) begin
          s[i] = a[i] ^ b[i] ^ c;
          c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
      end
    end
  endgenerate

endmodule

module sqr_seq_step
  import lau_pkg::*;
#(
  parameter int     width = 16,
  parameter int     digit = 2,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] M,
  input  logic [digit-1:0] D,
  input  logic [width-1:0] Ahi,
  output logic [width+digit:0] sum
);

  logic [width+digit-1:0] prod;

  assign prod = {{digit{1'b0}}, M} * {{width{1'b0}}, D};

  Add #(.width(width + digit + 1), .speed(speed)) u_add (
    .a({{(digit + 1){1'b0}}, Ahi}),
    .b({1'b0, prod}),
    .s(sum)
  );

endmodule

// File: rtl/sqr_seq_hs.sv
// Multi-cycle squarer P = X*X, digit multiplier bits per cycle, unsigned or two's-complement X.
// Result after width/digit cycles; DONE holds P until OutReady, a new operand may enter on that edge.
module sqr_seq_hs
  import lau_pkg::*;
#(
  parameter int     width = 16,
  parameter int     digit = 2,
  parameter speed_e speed = FAST
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TC,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [width-1:0]     X,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [2*width-1:0]   P
);

  localparam int n  = sqr_iter(width, digit);
  localparam int cw = sqr_cnt_w(width, digit);
  localparam logic [cw-1:0] last = cw'(n - 1);

  generate
    if ((width % digit) != 0 || (width % 2) != 0 || width < 4) begin : g_bad_param
      $error("sqr_seq_hs: width must be even, >= 4 and a multiple of digit");
    end
  endgenerate

  sqr_state_e             state;
  logic [width-1:0]       m;
  logic [width-1:0]       q;
  logic [2*width-1:0]     a;
  logic [cw-1:0]          cnt;
  logic [width-1:0]       abs_x;
  logic [width+digit:0]   sum;
  logic [2*width+digit:0] a_cat;
  logic [2*width-1:0]     a_nxt;
  logic                   accept;

  // -2^(width-1) negates to itself, which read as unsigned is the correct magnitude.
  assign abs_x = (TC && X[width-1]) ? -X : X;

  sqr_seq_step #(.width(width), .digit(digit), .speed(speed)) u_step (
    .M(m),
    .D(q[digit-1:0]),
    .Ahi(a[2*width-1:width]),
    .sum(sum)
  );

  // The step carry is always zero (A stays below 2^(2*width)), so truncation loses nothing.
  assign a_cat = {sum, a[width-1:0]};
  assign a_nxt = (2*width)'(a_cat >> digit);

  assign InReady = (state == IDLE) || ((state == DONE) && OutReady);
  assign accept  = InValid && InReady;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      P        <= '0;
      m        <= '0;
      q        <= '0;
      a        <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m     <= abs_x;
            q     <= abs_x;
            a     <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          a   <= a_nxt;
          q   <= q >> digit;
          cnt <= cnt + cw'(1);
          if (cnt == last) begin
            P        <= a_nxt;
            OutValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            if (accept) begin
              m     <= abs_x;
              q     <= abs_x;
              a     <= '0;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          OutValid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqr_seq_hs.sv
// Scoreboard bench for sqr_seq_hs: width=8/digit=2 directed cases plus a width=6 sweep over digit.
module tb_sqr_seq_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        tc = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] p;

  sqr_seq_hs #(.width(8), .digit(2)) dut (
    .CLK(clk), .RST(rst), .TC(tc), .InValid(in_valid), .InReady(in_ready),
    .X(x), .OutValid(out_valid), .OutReady(out_ready), .P(p)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  int          acc_q[$];
  int          rise_q[$];
  logic        prev_ov = 1'b0;
  int          last_acc = 0;
  logic        sweep_go = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] v, input logic s);
    int i;
    i = s ? int'($signed(v)) : int'(v);
    return 16'(i * i);
  endfunction

  function automatic logic [11:0] model6(input logic [5:0] v, input logic s);
    int i;
    i = s ? int'($signed(v)) : int'(v);
    return 12'(i * i);
  endfunction

  // Result monitor: latency on each OutValid rise, value on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        rise_q.push_back(cyc);
        if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), 4);
        else chk("unexpected_valid", out_valid, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("P", p, exp_q.pop_front());
        else chk("unexpected_result", out_valid, 0);
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [7:0] v, input logic s, input logic keep);
    int t;
    t = 0;
    in_valid = 1'b1;
    x = v;
    tc = s;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1;
    exp_q.push_back(model8(v, s));
    acc_q.push_back(cyc);
    last_acc = cyc;
    if (!keep) begin
      in_valid = 1'b0;
      x = 8'($urandom);
      tc = 1'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", (t >= 200) ? 1 : 0, 0);
    #1;
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int DG = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 6;
    localparam int NS = 6 / DG;
    logic        iv = 1'b0;
    logic        ir;
    logic        ov;
    logic        tcs = 1'b0;
    logic [5:0]  xs = '0;
    logic [11:0] ps;
    logic        fin = 1'b0;
    logic [11:0] sq[$];

    sqr_seq_hs #(.width(6), .digit(DG)) u_sw (
      .CLK(clk), .RST(rst), .TC(tcs), .InValid(iv), .InReady(ir),
      .X(xs), .OutValid(ov), .OutReady(1'b1), .P(ps)
    );

    initial begin
      int lat;
      int t;
      wait (sweep_go);
      for (int md = 0; md < 2; md++) begin
        for (int xi = 0; xi < 64; xi++) begin
          @(posedge clk);
          #1;
          iv = 1'b1;
          xs = 6'(xi);
          tcs = (md == 1);
          t = 0;
          @(negedge clk);
          while (!ir && t < 20) begin
            @(negedge clk);
            t++;
          end
          @(posedge clk);
          sq.push_back(model6(xs, tcs));
          #1;
          iv = 1'b0;
          lat = 0;
          while (!ov && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
          end
          chk($sformatf("sw_d%0d_lat x=%0h tc=%0d", DG, xi, md), lat, NS);
          chk($sformatf("sw_d%0d_p x=%0h tc=%0d", DG, xi, md), ps, sq.pop_front());
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    int acc2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(8'hFF, 1'b0, 1'b0);
    drain();
    send(8'h80, 1'b1, 1'b0);
    drain();
    send(8'hFF, 1'b1, 1'b0);
    drain();
    send(8'h7F, 1'b1, 1'b0);
    drain();

    // Backpressure: DONE must hold P and OutValid while OutReady is low.
    out_ready = 1'b0;
    send(8'h05, 1'b0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_rise", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_p", p, 16'h0019);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", out_valid, 0);
    drain();

    // Back-to-back: second operand enters on the first result's handshake edge.
    rise_q.delete();
    send(8'd3, 1'b0, 1'b1);
    send(8'd4, 1'b0, 1'b0);
    acc2 = last_acc;
    drain();
    chk("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() >= 2) begin
      chk("b2b_gap", rise_q[1] - rise_q[0], 5);
      chk("b2b_accept_edge", acc2, rise_q[0] + 1);
    end

    // Asynchronous reset in the second BUSY cycle.
    send(8'h55, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_p", p, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("arst_hold_out_valid", out_valid, 0);
    exp_q.delete();
    acc_q.delete();
    rst = 1'b0;
    send(8'h02, 1'b0, 1'b0);
    drain();

    sweep_go = 1'b1;
    t = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && t < 6000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep_done", (g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
